// File: rtl/rv32v_pkg.sv
// Shared encodings and the micro-op bundle for the RV32V issue sequencer.
package rv32v;

    typedef enum logic [6:0] {
        OPC_OP_V = 7'b1010111
    } opcode_e;

    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        OPCFG = 3'b111
    } funct3_e;

    typedef enum logic [5:0] {
        F6_VFADD      = 6'b000000,
        F6_VFSUB      = 6'b000010,
        F6_VFMIN      = 6'b000100,
        F6_VFMAX      = 6'b000110,
        F6_VFSGNJ     = 6'b001000,
        F6_VFSGNJN    = 6'b001001,
        F6_VFSGNJX    = 6'b001010,
        F6_VSLIDEUP   = 6'b001110,
        F6_VSLIDEDOWN = 6'b001111,
        F6_VFDIV      = 6'b100000,
        F6_VFRDIV     = 6'b100001,
        F6_VFMUL      = 6'b100100,
        F6_VFMACC     = 6'b101100,
        F6_VFNMACC    = 6'b101101,
        F6_VFMSAC     = 6'b101110,
        F6_VFNMSAC    = 6'b101111
    } funct6_e;

    typedef struct packed {
        logic [5:0]  funct6;
        logic [2:0]  funct3;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [31:0] scalar;
        logic        masked;
    } rv32v_uop_t;

    function automatic logic is_fp_arith(input logic [5:0] f6);
        case (f6)
            F6_VFADD, F6_VFSUB, F6_VFMIN, F6_VFMAX,
            F6_VFSGNJ, F6_VFSGNJN, F6_VFSGNJX,
            F6_VFDIV, F6_VFMUL, F6_VFMACC,
            F6_VFNMACC, F6_VFMSAC, F6_VFNMSAC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_decode.sv
// Combinational legality check of an OP-V instruction word.
module rv32v_decode
    import rv32v::*;
(
    input  logic [31:0] inst_word,
    output logic        legal,
    output logic        is_setvl
);

    logic [5:0] f6;
    logic [2:0] f3;
    logic       unused_bits;

    assign f6 = inst_word[31:26];
    assign f3 = inst_word[14:12];
    assign unused_bits = ^{inst_word[25:15], inst_word[11:7]};

    always_comb begin
        legal    = 1'b0;
        is_setvl = 1'b0;
        if (inst_word[6:0] == OPC_OP_V) begin
            case (f3)
                OPFVV: legal = is_fp_arith(f6);
                OPFVF: legal = is_fp_arith(f6) || (f6 == F6_VFRDIV);
                OPIVI, OPIVX:
                    legal = (f6 == F6_VSLIDEUP) || (f6 == F6_VSLIDEDOWN);
                OPCFG: begin
                    legal    = 1'b1;
                    is_setvl = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rv32v_sequencer.sv
// Accepts OP-V instructions, tracks vl and issues LANES-wide micro-op beats.
module rv32v_sequencer
    import rv32v::*;
#(
    parameter int LANES = 4,
    parameter int VLMAX = 32,
    localparam int IDXW = $clog2(VLMAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst_word,
    input  logic [31:0]      inst_rs1_value,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [5:0]       uop_funct6,
    output logic [2:0]       uop_funct3,
    output logic [4:0]       uop_vd,
    output logic [4:0]       uop_vs1,
    output logic [4:0]       uop_vs2,
    output logic [31:0]      uop_scalar,
    output logic [IDXW-1:0]  uop_index,
    output logic [LANES-1:0] uop_lane_enable,
    output logic             uop_masked,
    output logic             uop_last,
    output logic             vl_wb_valid,
    output logic [4:0]       vl_wb_rd,
    output logic [31:0]      vl_wb_value,
    output logic             illegal,
    output logic             busy
);

    // Two spare bits so index+LANES and vl==VLMAX never wrap.
    localparam int CW = IDXW + 2;

    typedef enum logic {S_IDLE, S_ISSUE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] vl_q, vl_d;
    logic [CW-1:0] idx_q, idx_d;
    rv32v_uop_t    uop_q, uop_d;
    logic          illegal_q, illegal_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [CW-1:0] wb_val_q, wb_val_d;

    logic          legal, is_setvl, accept, last_beat;
    logic [CW-1:0] setvl_val;
    logic [31:0]   scalar_val;

    rv32v_decode u_decode (
        .inst_word (inst_word),
        .legal     (legal),
        .is_setvl  (is_setvl)
    );

    assign accept    = inst_valid && (state_q == S_IDLE);
    assign last_beat = (idx_q + CW'(LANES)) >= vl_q;

    always_comb begin
        if (inst_word[19:15] == 5'd0 && inst_word[11:7] != 5'd0)
            setvl_val = CW'(VLMAX);
        else if (inst_rs1_value > 32'(VLMAX))
            setvl_val = CW'(VLMAX);
        else
            setvl_val = inst_rs1_value[CW-1:0];
    end

    always_comb begin
        case (inst_word[14:12])
            OPIVX, OPFVF: scalar_val = inst_rs1_value;
            OPIVI:        scalar_val = {27'd0, inst_word[19:15]};
            default:      scalar_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        vl_d       = vl_q;
        idx_d      = idx_q;
        uop_d      = uop_q;
        illegal_d  = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_val_d   = wb_val_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else if (is_setvl) begin
                        vl_d       = setvl_val;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = inst_word[11:7];
                        wb_val_d   = setvl_val;
                    end else if (vl_q != '0) begin
                        state_d = S_ISSUE;
                        idx_d   = '0;
                        uop_d   = '{
                            funct6: inst_word[31:26],
                            funct3: inst_word[14:12],
                            vd:     inst_word[11:7],
                            vs1:    inst_word[19:15],
                            vs2:    inst_word[24:20],
                            scalar: scalar_val,
                            masked: ~inst_word[25]
                        };
                    end
                end
            end
            S_ISSUE: begin
                if (uop_ready) begin
                    if (last_beat) state_d = S_IDLE;
                    else           idx_d   = idx_q + CW'(LANES);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vl_q       <= '0;
            idx_q      <= '0;
            uop_q      <= '0;
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            vl_q       <= vl_d;
            idx_q      <= idx_d;
            uop_q      <= uop_d;
            illegal_q  <= illegal_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++)
            uop_lane_enable[k] = (state_q == S_ISSUE) && ((idx_q + CW'(k)) < vl_q);
    end

    assign inst_ready  = (state_q == S_IDLE);
    assign busy        = (state_q == S_ISSUE);
    assign uop_valid   = (state_q == S_ISSUE);
    assign uop_last    = (state_q == S_ISSUE) && last_beat;
    assign uop_index   = idx_q[IDXW-1:0];
    assign uop_funct6  = uop_q.funct6;
    assign uop_funct3  = uop_q.funct3;
    assign uop_vd      = uop_q.vd;
    assign uop_vs1     = uop_q.vs1;
    assign uop_vs2     = uop_q.vs2;
    assign uop_scalar  = uop_q.scalar;
    assign uop_masked  = uop_q.masked;
    assign illegal     = illegal_q;
    assign vl_wb_valid = wb_valid_q;
    assign vl_wb_rd    = wb_rd_q;
    assign vl_wb_value = {{(32-CW){1'b0}}, wb_val_q};

endmodule

// File: tb/tb_rv32v_sequencer.sv
// Scoreboard bench for rv32v_sequencer with LANES=4, VLMAX=32.
module tb_rv32v_sequencer;

    localparam int LANES = 4;
    localparam int VLMAX = 32;
    localparam int IDXW  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inst_valid = 1'b0;
    logic             inst_ready;
    logic [31:0]      inst_word = '0;
    logic [31:0]      inst_rs1_value = '0;
    logic             uop_valid;
    logic             uop_ready = 1'b0;
    logic [5:0]       uop_funct6;
    logic [2:0]       uop_funct3;
    logic [4:0]       uop_vd, uop_vs1, uop_vs2;
    logic [31:0]      uop_scalar;
    logic [IDXW-1:0]  uop_index;
    logic [LANES-1:0] uop_lane_enable;
    logic             uop_masked, uop_last;
    logic             vl_wb_valid;
    logic [4:0]       vl_wb_rd;
    logic [31:0]      vl_wb_value;
    logic             illegal, busy;

    rv32v_sequencer #(.LANES(LANES), .VLMAX(VLMAX)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_rs1_value(inst_rs1_value),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_funct6(uop_funct6), .uop_funct3(uop_funct3),
        .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
        .uop_scalar(uop_scalar), .uop_index(uop_index),
        .uop_lane_enable(uop_lane_enable), .uop_masked(uop_masked),
        .uop_last(uop_last), .vl_wb_valid(vl_wb_valid),
        .vl_wb_rd(vl_wb_rd), .vl_wb_value(vl_wb_value),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDXW-1:0]  idx;
        logic [LANES-1:0] en;
        logic             last;
        logic [5:0]       f6;
        logic [2:0]       f3;
        logic [4:0]       vd, vs1, vs2;
        logic [31:0]      scalar;
        logic             masked;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    tb_vl  = 0;

    localparam logic [5:0] VFADD    = 6'b000000;
    localparam logic [5:0] VFMUL    = 6'b100100;
    localparam logic [5:0] VFRDIV   = 6'b100001;
    localparam logic [5:0] VSLIDEUP = 6'b001110;
    localparam logic [2:0] FVV = 3'b001, IVI = 3'b011;
    localparam logic [2:0] FVF = 3'b101, CFG = 3'b111;

    function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm,
                                       input logic [4:0] vs2, input logic [4:0] vs1,
                                       input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    // Scoreboard side: compare each handshaken beat with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && uop_valid && uop_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat index=%0d", uop_index);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (uop_index !== e.idx || uop_lane_enable !== e.en ||
                    uop_last !== e.last || uop_funct6 !== e.f6 ||
                    uop_funct3 !== e.f3 || uop_vd !== e.vd ||
                    uop_vs1 !== e.vs1 || uop_vs2 !== e.vs2 ||
                    uop_scalar !== e.scalar || uop_masked !== e.masked) begin
                    errors++;
                    $display("FAIL beat got idx=%0d en=%b last=%b f6=%h f3=%h vd=%0d vs1=%0d vs2=%0d sc=%h m=%b want idx=%0d en=%b last=%b f6=%h f3=%h vd=%0d vs1=%0d vs2=%0d sc=%h m=%b",
                             uop_index, uop_lane_enable, uop_last, uop_funct6, uop_funct3,
                             uop_vd, uop_vs1, uop_vs2, uop_scalar, uop_masked,
                             e.idx, e.en, e.last, e.f6, e.f3, e.vd, e.vs1, e.vs2,
                             e.scalar, e.masked);
                end
            end
        end
    end

    task automatic push_beats(input logic [31:0] w, input logic [31:0] rs1);
        beat_t b;
        for (int n = 0; n * LANES < tb_vl; n++) begin
            b.idx  = IDXW'(n * LANES);
            for (int k = 0; k < LANES; k++) b.en[k] = (n * LANES + k) < tb_vl;
            b.last = ((n + 1) * LANES) >= tb_vl;
            b.f6   = w[31:26];
            b.f3   = w[14:12];
            b.vd   = w[11:7];
            b.vs1  = w[19:15];
            b.vs2  = w[24:20];
            b.masked = ~w[25];
            if (w[14:12] == FVF || w[14:12] == 3'b100) b.scalar = rs1;
            else if (w[14:12] == IVI) b.scalar = {27'd0, w[19:15]};
            else b.scalar = 32'd0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] rs1);
        @(posedge clk); #1;
        inst_valid = 1'b1;
        inst_word = w;
        inst_rs1_value = rs1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || !inst_ready) && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        checks++;
        if (exp_q.size() != 0 || !inst_ready) begin
            errors++;
            $display("FAIL drain_timeout left=%0d inst_ready=%b", exp_q.size(), inst_ready);
        end
    endtask

    task automatic do_setvl(input logic [4:0] rs1f, input logic [4:0] rd,
                            input logic [31:0] val, input int expv);
        send(mk(6'd0, 1'b1, 5'd0, rs1f, CFG, rd), val);
        checks++;
        if (vl_wb_valid !== 1'b1 || vl_wb_rd !== rd || vl_wb_value !== 32'(expv)) begin
            errors++;
            $display("FAIL setvl got v=%b rd=%0d val=%0d want v=1 rd=%0d val=%0d",
                     vl_wb_valid, vl_wb_rd, vl_wb_value, rd, expv);
        end
        tb_vl = expv;
        @(posedge clk); #1;
        checks++;
        if (vl_wb_valid !== 1'b0 || uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL setvl_pulse got wb=%b uop_valid=%b want 0 0", vl_wb_valid, uop_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (uop_valid !== 0 || busy !== 0 || illegal !== 0 || vl_wb_valid !== 0 ||
            uop_index !== 0 || uop_lane_enable !== 0 || uop_last !== 0 ||
            uop_scalar !== 0 || vl_wb_value !== 0 || inst_ready !== 1) begin
            errors++;
            $display("FAIL reset got v=%b busy=%b ill=%b wb=%b idx=%0d en=%b last=%b sc=%h wbv=%0d rdy=%b want zeros rdy=1",
                     uop_valid, busy, illegal, vl_wb_valid, uop_index, uop_lane_enable,
                     uop_last, uop_scalar, vl_wb_value, inst_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_setvl();
        do_setvl(5'd1, 5'd5, 32'd100, 32);
    endtask

    task automatic test_arith();
        logic [31:0] w;
        int cyc;
        do_setvl(5'd1, 5'd1, 32'd10, 10);
        w = mk(VFADD, 1'b1, 5'd3, 5'd4, FVV, 5'd2);
        uop_ready = 1'b1;
        push_beats(w, 32'd0);
        send(w, 32'd0);
        checks++;
        if (uop_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arith_start got valid=%b busy=%b want 1 1", uop_valid, busy);
        end
        wait_drain(20, cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL arith_cycles got %0d want 3", cyc);
        end
    endtask

    task automatic test_frdiv();
        logic [31:0] w;
        int cyc;
        do_setvl(5'd1, 5'd1, 32'd8, 8);
        send(mk(VFRDIV, 1'b1, 5'd6, 5'd7, FVV, 5'd8), 32'd0);
        checks++;
        if (illegal !== 1'b1 || uop_valid !== 1'b0 || inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL frdiv_fvv got ill=%b valid=%b rdy=%b want 1 0 1",
                     illegal, uop_valid, inst_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b0 || uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL frdiv_pulse got ill=%b valid=%b want 0 0", illegal, uop_valid);
        end
        w = mk(VFRDIV, 1'b1, 5'd6, 5'd7, FVF, 5'd8);
        push_beats(w, 32'h3F80_0000);
        send(w, 32'h3F80_0000);
        wait_drain(20, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL frdiv_cycles got %0d want 2", cyc);
        end
    endtask

    task automatic test_slide_stall();
        logic [31:0] w;
        int cyc;
        w = mk(VSLIDEUP, 1'b1, 5'd9, 5'd3, IVI, 5'd10);
        uop_ready = 1'b0;
        push_beats(w, 32'hDEAD_BEEF);
        send(w, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (uop_valid !== 1 || uop_index !== 0 || uop_scalar !== 32'd3 ||
                uop_lane_enable !== 4'hF || uop_last !== 0 || uop_vd !== 5'd10) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d sc=%h en=%b last=%b vd=%0d want 1 0 3 1111 0 10",
                         i, uop_valid, uop_index, uop_scalar, uop_lane_enable, uop_last, uop_vd);
            end
            @(posedge clk); #1;
        end
        uop_ready = 1'b1;
        wait_drain(20, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL slide_cycles got %0d want 2", cyc);
        end
    endtask

    task automatic test_vl_zero();
        do_setvl(5'd1, 5'd4, 32'd0, 0);
        send(mk(VFADD, 1'b1, 5'd1, 5'd2, FVV, 5'd3), 32'd0);
        checks++;
        if (uop_valid !== 0 || illegal !== 0 || busy !== 0 || inst_ready !== 1) begin
            errors++;
            $display("FAIL vl_zero got v=%b ill=%b busy=%b rdy=%b want 0 0 0 1",
                     uop_valid, illegal, busy, inst_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (uop_valid !== 0 || vl_wb_valid !== 0) begin
            errors++;
            $display("FAIL vl_zero_after got v=%b wb=%b want 0 0", uop_valid, vl_wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int cyc;
        do_setvl(5'd0, 5'd3, 32'd5, VLMAX);
        w = mk(VFMUL, 1'b0, 5'd11, 5'd12, FVV, 5'd13);
        push_beats(w, 32'd0);
        send(w, 32'd0);
        wait_drain(40, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL b2b_cycles got %0d want 8", cyc);
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [31:0] w;
        do_setvl(5'd1, 5'd1, 32'd20, 20);
        w = mk(VFADD, 1'b1, 5'd1, 5'd2, FVV, 5'd3);
        uop_ready = 1'b0;
        send(w, 32'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (uop_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL mid_reset got v=%b busy=%b want 0 0", uop_valid, busy);
        end
        exp_q.delete();
        tb_vl = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        uop_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (inst_ready !== 1 || uop_valid !== 0) begin
            errors++;
            $display("FAIL after_reset got rdy=%b v=%b want 1 0", inst_ready, uop_valid);
        end
        do_setvl(5'd0, 5'd0, 32'd0, 0);
    endtask

    initial begin
        test_reset();
        test_setvl();
        test_arith();
        test_frdiv();
        test_slide_stall();
        test_vl_zero();
        test_back_to_back();
        test_reset_mid_issue();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
